dkong_sound_latch: RTL

- Main-CPU-side transmitter for the sound-command interface. Owns the 74LS259/74LS174-equivalent latches that drive the sound board's command inputs: 6H and 4H addressable latches, the 5H bit 0 latch, and the 3D data latch.
- Stretches short trigger pulses so the slow-polling 8035 and the wav sequencer always see them.
- Synchronises the sound board's SACK return and exposes a command-busy handshake flag to the main CPU.

---
 rtl/dkong_snd_pkg.sv | 16 +
 rtl/dkong_trig_stretch.sv | 41 ++++
 rtl/dkong_sound_latch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dkong_snd_pkg.sv
// Shared types and sizes for the Donkey Kong main-CPU sound-command latch.
package dkong_snd_pkg;

   localparam int H6_W = 7;
   localparam int H4_W = 2;
   localparam int D3_W = 5;

   localparam int DEF_STRETCH_CYCLES = 4096;
   localparam int DEF_BUSY_TIMEOUT   = 65535;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } busy_state_t;

endpackage

// File: rtl/dkong_trig_stretch.sv
// Single-bit pulse stretcher: output held high CYCLES clocks after raw rises.
module dkong_trig_stretch #(
   parameter int CYCLES = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic q
);

   localparam int CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

   logic          raw_q;
   logic          raw_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      raw_d = raw;
      cnt_d = cnt_q;
      if (raw && !raw_q) begin
         cnt_d = LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         raw_q <= raw_d;
         cnt_q <= cnt_d;
      end
   end

   assign q = raw | (cnt_q != '0);

endmodule

// File: rtl/dkong_sound_latch.sv
// Main-CPU sound-command latches, trigger stretch, SACK sync and busy flag.
// Optional readback port enabled by DKONG_SND_LATCH_RDBK_EN.
module dkong_sound_latch
   import dkong_snd_pkg::*;
#(
   parameter int               STRETCH_CYCLES = DEF_STRETCH_CYCLES,
   parameter logic [H6_W-1:0]  STRETCH_MASK   = 7'b0000111,
   parameter int               BUSY_TIMEOUT   = DEF_BUSY_TIMEOUT
) (
   input  logic            W_CLK_24576M,
   input  logic            W_RESETn,
   input  logic [2:0]      I_A,
   input  logic [7:0]      I_D,
   input  logic            I_6H_WE,
   input  logic            I_5H_WE,
   input  logic            I_4H_WE,
   input  logic            I_3D_WE,
   input  logic            I_SACK,
   output logic [H6_W-1:0] O_6H_Q,
   output logic            O_5H_Q0,
   output logic [H4_W-1:0] O_4H_Q,
   output logic [D3_W-1:0] O_3D_Q,
   output logic            O_SACK,
   output logic            O_BUSY
`ifdef DKONG_SND_LATCH_RDBK_EN
   ,
   output logic [7:0]      O_RDBK
`endif
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TLOAD = TW'(BUSY_TIMEOUT);

   logic [1:0]      rst_sync_q;
   logic            rst_n;

   logic [H6_W-1:0] h6_q, h6_d;
   logic            h5_q, h5_d;
   logic [H4_W-1:0] h4_q, h4_d;
   logic [D3_W-1:0] d3_q, d3_d;
   logic [2:0]      sack_q, sack_d;
   logic            sack_edge;
   busy_state_t     state_q, state_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            unused_d;

   // Assert asynchronously, release on the clock.
   always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
      if (!W_RESETn) rst_sync_q <= 2'b00;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n    = rst_sync_q[1];
   assign unused_d = ^I_D[7:D3_W];

   always_comb begin
      h6_d = h6_q;
      h5_d = h5_q;
      h4_d = h4_q;
      d3_d = d3_q;
      for (int i = 0; i < H6_W; i++) begin
         if (I_6H_WE && I_A == 3'(i)) h6_d[i] = I_D[0];
      end
      if (I_5H_WE && I_A == 3'd0) h5_d = I_D[0];
      if (I_4H_WE && I_A[2:1] == 2'b00) h4_d[I_A[0]] = I_D[0];
      if (I_3D_WE) d3_d = I_D[D3_W-1:0];
   end

   assign sack_d    = {sack_q[1:0], I_SACK};
   assign sack_edge = sack_q[1] ^ sack_q[2];

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         IDLE: begin
            if (I_3D_WE) begin
               state_d = WAIT;
               tmo_d   = TLOAD;
            end
         end
         WAIT: begin
            if (I_3D_WE) begin
               tmo_d = TLOAD;
            end else if (sack_edge || tmo_q == '0) begin
               state_d = IDLE;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge W_CLK_24576M or negedge rst_n) begin
      if (!rst_n) begin
         h6_q    <= '0;
         h5_q    <= 1'b0;
         h4_q    <= '0;
         d3_q    <= '0;
         sack_q  <= '0;
         state_q <= IDLE;
         tmo_q   <= '0;
      end else begin
         h6_q    <= h6_d;
         h5_q    <= h5_d;
         h4_q    <= h4_d;
         d3_q    <= d3_d;
         sack_q  <= sack_d;
         state_q <= state_d;
         tmo_q   <= tmo_d;
      end
   end

   for (genvar b = 0; b < H6_W; b++) begin : g_h6
      if (STRETCH_MASK[b]) begin : g_str
         dkong_trig_stretch #(
            .CYCLES (STRETCH_CYCLES)
         ) u_str (
            .clk   (W_CLK_24576M),
            .rst_n (rst_n),
            .raw   (h6_q[b]),
            .q     (O_6H_Q[b])
         );
      end else begin : g_raw
         assign O_6H_Q[b] = h6_q[b];
      end
   end

   assign O_5H_Q0 = h5_q;
   assign O_4H_Q  = h4_q;
   assign O_3D_Q  = d3_q;
   assign O_SACK  = sack_q[1];
   assign O_BUSY  = (state_q == WAIT);

`ifdef DKONG_SND_LATCH_RDBK_EN
   logic [7:0] rdbk_q, rdbk_d;

   assign rdbk_d = {O_BUSY, O_SACK, 1'b0, d3_q};

   always_ff @(posedge W_CLK_24576M or negedge rst_n) begin
      if (!rst_n) rdbk_q <= '0;
      else        rdbk_q <= rdbk_d;
   end

   assign O_RDBK = rdbk_q;
`endif

endmodule
